// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Multi-cycle data memory seen from the load/store unit. One request is
//   accepted at a time, held for LATENCY wait cycles, then the byte-masked
//   write is committed (or the read word returned) together with a
//   one-cycle mem_ready pulse that releases the pipeline stall.
//
//   Timing from the accept edge E0: the response edge is E0+LATENCY (for
//   LATENCY=0 this is E0 itself), so mem_ready is high in the
//   (LATENCY+1)-th cycle after E0. mem_busy covers those same LATENCY+1
//   cycles. The earliest next accept is two edges after the response edge.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   cs           request strobe, sampled only while idle
//   wr_en        1 = write, 0 = read (sampled with cs)
//   mask[3:0]    byte enables for writes, bit i -> Mem_inData[8i+7:8i]
//   Mem_Addr     byte address, bits [1:0] ignored
//   Mem_inData   write data
//   Mem_outData  registered read data, held until the next read response
//   mem_ready    one-cycle response pulse
//   mem_err      out-of-range flag, pulses with mem_ready
//   mem_busy     request in flight
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        wr_en,
    input  logic [3:0]  mask,
    input  logic [31:0] Mem_Addr,
    input  logic [31:0] Mem_inData,
    output logic [31:0] Mem_outData,
    output logic        mem_ready,
    output logic        mem_err,
    output logic        mem_busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  LAT   = 4'(LATENCY);

    logic [1:0]  state;
    logic [3:0]  cnt;

    // Request latch (data path, not reset)
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_mask;
    logic        req_wr;

    logic [31:0] mem [DEPTH_WORDS];

    // Request currently being completed and its decode
    logic        accept;
    logic        fire;
    logic [31:0] act_addr;
    logic [31:0] act_data;
    logic [3:0]  act_mask;
    logic        act_wr;
    logic [31:0] off;
    logic        in_range;
    logic [IDX_W-1:0] idx;

    always_comb begin
        accept = (state == IDLE) && cs;
        // With zero wait cycles the response edge is the accept edge, so the
        // live inputs are used instead of the (not yet loaded) latch.
        if (LATENCY == 0) begin
            fire     = accept;
            act_addr = Mem_Addr;
            act_data = Mem_inData;
            act_mask = mask;
            act_wr   = wr_en;
        end else begin
            fire     = (state == WAIT) && (cnt == 4'd1);
            act_addr = req_addr;
            act_data = req_data;
            act_mask = req_mask;
            act_wr   = req_wr;
        end
        off      = act_addr - BASE_ADDR;
        in_range = ({1'b0, off} < LIMIT);
        idx      = off[IDX_W+1:2];
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            req_addr <= Mem_Addr;
            req_data <= Mem_inData;
            req_mask <= mask;
            req_wr   <= wr_en;
        end
    end

    // Array write; a reset on the response edge suppresses it.
    always_ff @(posedge clk) begin
        if (reset && fire && act_wr && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (act_mask[i]) begin
                    mem[idx][8*i +: 8] <= act_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            mem_ready   <= 1'b0;
            mem_err     <= 1'b0;
            mem_busy    <= 1'b0;
            Mem_outData <= 32'd0;
        end else begin
            mem_ready <= fire;
            mem_err   <= fire && !in_range;
            if (fire && !act_wr) begin
                Mem_outData <= in_range ? mem[idx] : 32'd0;
            end
            case (state)
                IDLE: begin
                    if (cs) begin
                        state    <= (LATENCY == 0) ? RESP : WAIT;
                        cnt      <= LAT;
                        mem_busy <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    mem_busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    mem_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: four instances (LATENCY 2, 0, 15, 4), a
// transaction-level reference model compared every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_data_mem_responder;

    localparam int NI = 4;
    int LATS [NI] = '{2, 0, 15, 4};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v  [NI];
    logic        cs_v   [NI];
    logic        wr_v   [NI];
    logic [3:0]  mask_v [NI];
    logic [31:0] addr_v [NI];
    logic [31:0] din_v  [NI];
    logic [31:0] out_v  [NI];
    logic        rdy_v  [NI];
    logic        err_v  [NI];
    logic        busy_v [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned L = (g == 0) ? 2 : (g == 1) ? 0 : (g == 2) ? 15 : 4;
        data_mem_responder #(
            .DEPTH_WORDS(1024),
            .LATENCY(L),
            .BASE_ADDR(32'h0000_0000)
        ) dut (
            .clk(clk),
            .reset(rst_v[g]),
            .cs(cs_v[g]),
            .wr_en(wr_v[g]),
            .mask(mask_v[g]),
            .Mem_Addr(addr_v[g]),
            .Mem_inData(din_v[g]),
            .Mem_outData(out_v[g]),
            .mem_ready(rdy_v[g]),
            .mem_err(err_v[g]),
            .mem_busy(busy_v[g])
        );
    end

    int errors = 0;
    int checks = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    bit          m_ok   [NI];
    bit          m_fl   [NI];
    int          m_age  [NI];
    bit          m_wr   [NI];
    logic [3:0]  m_mask [NI];
    logic [31:0] m_addr [NI];
    logic [31:0] m_data [NI];
    bit          e_rdy  [NI];
    bit          e_err  [NI];
    bit          e_busy [NI];
    logic [31:0] e_out  [NI];
    bit          e_known[NI];
    logic [31:0] mw [NI][1024];
    bit          mk [NI][1024];

    function automatic void respond(int k);
        logic [31:0] off;
        int idx;
        bit inr;
        off = m_addr[k];
        inr = (off < 32'd4096);
        idx = int'(off >> 2);
        e_rdy[k] = 1;
        e_err[k] = !inr;
        if (m_wr[k]) begin
            if (inr) begin
                for (int b = 0; b < 4; b++)
                    if (m_mask[k][b]) mw[k][idx][8*b +: 8] = m_data[k][8*b +: 8];
                if (m_mask[k] != 4'hF && !mk[k][idx]) mk[k][idx] = 0;
                else if (m_mask[k] == 4'hF) mk[k][idx] = 1;
            end
        end else if (inr) begin
            e_out[k]   = mw[k][idx];
            e_known[k] = mk[k][idx];
        end else begin
            e_out[k]   = 32'd0;
            e_known[k] = 1;
        end
    endfunction

    function automatic void model_step(int k, bit rn, bit c, bit w, logic [3:0] m,
                                       logic [31:0] a, logic [31:0] d);
        e_rdy[k] = 0;
        e_err[k] = 0;
        if (!rn) begin
            m_ok[k] = 1; m_fl[k] = 0; e_busy[k] = 0;
            e_out[k] = 32'd0; e_known[k] = 1;
            return;
        end
        if (m_fl[k]) begin
            m_age[k]++;
            if (m_age[k] == LATS[k]) respond(k);
            else if (m_age[k] == LATS[k] + 1) begin
                m_fl[k] = 0; e_busy[k] = 0;
            end
        end else if (c) begin
            m_fl[k] = 1; m_age[k] = 0; e_busy[k] = 1;
            m_wr[k] = w; m_mask[k] = m; m_addr[k] = a; m_data[k] = d;
            if (LATS[k] == 0) respond(k);
        end
    endfunction

    // Compare process: inputs captured at negedge are those sampled at the next edge.
    initial begin : monitor
        logic p_rst [NI];
        logic p_cs  [NI];
        logic p_wr  [NI];
        logic [3:0]  p_m [NI];
        logic [31:0] p_a [NI];
        logic [31:0] p_d [NI];
        #1;
        for (int k = 0; k < NI; k++) begin
            p_rst[k] = rst_v[k]; p_cs[k] = cs_v[k]; p_wr[k] = wr_v[k];
            p_m[k] = mask_v[k]; p_a[k] = addr_v[k]; p_d[k] = din_v[k];
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                model_step(k, p_rst[k], p_cs[k], p_wr[k], p_m[k], p_a[k], p_d[k]);
                if (m_ok[k]) begin
                    chk($sformatf("mon%0d ready", k), {31'd0, rdy_v[k]}, {31'd0, e_rdy[k]});
                    chk($sformatf("mon%0d err", k), {31'd0, err_v[k]}, {31'd0, e_err[k]});
                    chk($sformatf("mon%0d busy", k), {31'd0, busy_v[k]}, {31'd0, e_busy[k]});
                    if (e_known[k]) chk($sformatf("mon%0d rdata", k), out_v[k], e_out[k]);
                end
                p_rst[k] = rst_v[k]; p_cs[k] = cs_v[k]; p_wr[k] = wr_v[k];
                p_m[k] = mask_v[k]; p_a[k] = addr_v[k]; p_d[k] = din_v[k];
            end
        end
    end

    // ---------------- driver ----------------
    // One request on instance k; poke>0 raises cs in that cycle after accept.
    task automatic do_req(input int k, input bit w, input logic [3:0] m,
                          input logic [31:0] a, input logic [31:0] d, input int poke,
                          output logic [31:0] rd, output bit er, output int lat,
                          output int bcnt);
        bit got;
        @(posedge clk); #2;
        cs_v[k] = 1; wr_v[k] = w; mask_v[k] = m; addr_v[k] = a; din_v[k] = d;
        @(posedge clk); #2;
        cs_v[k] = 0;
        got = 0; lat = 0; bcnt = 0; rd = 32'd0; er = 0;
        for (int c = 1; c <= 40 && !got; c++) begin
            if (c == poke) begin
                cs_v[k] = 1; wr_v[k] = 1; mask_v[k] = 4'hF;
                addr_v[k] = 32'h3C; din_v[k] = $urandom;
            end else begin
                cs_v[k] = 0;
            end
            @(negedge clk);
            if (busy_v[k]) bcnt++;
            if (rdy_v[k]) begin
                got = 1; lat = c; rd = out_v[k]; er = err_v[k];
            end else begin
                @(posedge clk); #2;
            end
        end
        if (!got) chk($sformatf("timeout inst%0d", k), 32'd0, 32'd1);
        @(posedge clk); #2;
        cs_v[k] = 0;
    endtask

    initial begin : driver
        logic [31:0] rd;
        bit er;
        int lat, bc, cnt;
        for (int k = 0; k < NI; k++) begin
            rst_v[k] = 0; cs_v[k] = 0; wr_v[k] = 0; mask_v[k] = 0;
            addr_v[k] = 0; din_v[k] = 0;
        end
        repeat (2) @(posedge clk);
        #2;
        for (int k = 0; k < NI; k++) rst_v[k] = 1;

        // Reset then idle
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                chk($sformatf("idle%0d ready", k), {31'd0, rdy_v[k]}, 32'd0);
                chk($sformatf("idle%0d busy", k), {31'd0, busy_v[k]}, 32'd0);
                chk($sformatf("idle%0d out", k), out_v[k], 32'd0);
            end
        end

        // Preload the words used by random traffic
        for (int k = 0; k < NI; k++) begin
            for (int w = 0; w < 16; w++)
                do_req(k, 1, 4'hF, 32'(w * 4), $urandom, 0, rd, er, lat, bc);
            do_req(k, 1, 4'hF, 32'hFFC, 32'hCAFE_F00D, 0, rd, er, lat, bc);
        end

        // Full-word write/read, LATENCY=2
        do_req(0, 1, 4'hF, 32'h10, 32'hDEAD_BEEF, 0, rd, er, lat, bc);
        chk("l2 write latency", 32'(lat), 32'd3);
        chk("l2 busy cycles", 32'(bc), 32'd3);
        do_req(0, 0, 4'h0, 32'h10, 32'h0, 0, rd, er, lat, bc);
        chk("l2 read data", rd, 32'hDEAD_BEEF);
        chk("l2 read err", {31'd0, er}, 32'd0);

        // Byte masks
        do_req(0, 1, 4'hF, 32'h20, 32'h1122_3344, 0, rd, er, lat, bc);
        do_req(0, 1, 4'b0101, 32'h20, 32'hAABB_CCDD, 0, rd, er, lat, bc);
        do_req(0, 0, 4'hF, 32'h20, 32'h0, 0, rd, er, lat, bc);
        chk("mask 0101 data", rd, 32'h11BB_33DD);
        do_req(0, 1, 4'b0000, 32'h20, 32'hFFFF_FFFF, 0, rd, er, lat, bc);
        do_req(0, 0, 4'hF, 32'h20, 32'h0, 0, rd, er, lat, bc);
        chk("mask 0 data", rd, 32'h11BB_33DD);

        // Out of range
        do_req(0, 1, 4'hF, 32'h1000, 32'h1234_5678, 0, rd, er, lat, bc);
        chk("oor write err", {31'd0, er}, 32'd1);
        do_req(0, 0, 4'hF, 32'h1000, 32'h0, 0, rd, er, lat, bc);
        chk("oor read err", {31'd0, er}, 32'd1);
        chk("oor read data", rd, 32'd0);
        do_req(0, 0, 4'hF, 32'hFFC, 32'h0, 0, rd, er, lat, bc);
        chk("last word data", rd, 32'hCAFE_F00D);
        chk("last word err", {31'd0, er}, 32'd0);

        // LATENCY=0
        do_req(1, 1, 4'hF, 32'h8, 32'h0102_0304, 0, rd, er, lat, bc);
        chk("l0 latency", 32'(lat), 32'd1);
        chk("l0 busy cycles", 32'(bc), 32'd1);
        do_req(1, 0, 4'hF, 32'h8, 32'h0, 0, rd, er, lat, bc);
        chk("l0 read data", rd, 32'h0102_0304);

        // LATENCY=15 with a cs pulse during the wait
        do_req(2, 0, 4'hF, 32'hFFC, 32'h0, 5, rd, er, lat, bc);
        chk("l15 latency", 32'(lat), 32'd16);
        chk("l15 busy cycles", 32'(bc), 32'd16);
        chk("l15 read data", rd, 32'hCAFE_F00D);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rdy_v[2]) cnt++;
        end
        chk("l15 extra responses", 32'(cnt), 32'd0);

        // Reset mid-operation, LATENCY=4
        do_req(3, 1, 4'hF, 32'h40, 32'h0BAD_C0DE, 0, rd, er, lat, bc);
        @(posedge clk); #2;
        cs_v[3] = 1; wr_v[3] = 1; mask_v[3] = 4'hF; addr_v[3] = 32'h40; din_v[3] = 32'h5555_5555;
        @(posedge clk); #2;
        cs_v[3] = 0;
        repeat (3) @(posedge clk);
        #2; rst_v[3] = 0;
        @(posedge clk); #2; rst_v[3] = 1;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rdy_v[3]) cnt++;
        end
        chk("mid reset responses", 32'(cnt), 32'd0);
        do_req(3, 0, 4'hF, 32'h40, 32'h0, 0, rd, er, lat, bc);
        chk("mid reset prior data", rd, 32'h0BAD_C0DE);

        // Randomized traffic, checked by the monitor
        for (int k = 0; k < NI; k++) begin
            for (int n = 0; n < 40; n++) begin
                int sel;
                logic [31:0] a;
                sel = $urandom_range(0, 9);
                if (sel < 7)       a = 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
                else if (sel == 7) a = 32'hFFC;
                else if (sel == 8) a = 32'h1000 + 32'($urandom_range(0, 63) * 4);
                else               a = $urandom;
                do_req(k, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom,
                       $urandom_range(0, LATS[k] + 1), rd, er, lat, bc);
                chk($sformatf("rand%0d latency", k), 32'(lat), 32'(LATS[k] + 1));
                repeat ($urandom_range(0, 2)) @(posedge clk);
            end
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
